// File: rtl/clk_divider_n.sv
// clk_divider_n: programmable divide-by-N clock-enable generator with glitch-free divisor reload
//   clk, rst_n       : system clock, async active-low reset
//   en               : count enable (phase held when low)
//   load_valid/div   : offered divisor, accepted while load_ready; 0 is rejected with load_err
//   out_d, tick      : registered divided waveform and period-wrap pulse
//   div_active       : divisor in effect; period_count: completed periods mod 2^16
module clk_divider_n #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_div,
  output logic             load_ready,
  output logic             load_err,
  output logic             out_d,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic [15:0]      period_count
);
  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_n, div_q, div_d, pdiv_q, pdiv_d;
  logic [15:0] pc_q, pc_d;
  logic pend_q, pend_d, wave_q, wave_d, tick_q, tick_d, err_q, err_d;
  logic last, apply, offer, take;
  always_comb begin
    last   = cnt_q == div_q - WIDTH'(1);
    cnt_n  = last ? '0 : cnt_q + WIDTH'(1);
    offer  = load_valid && !pend_q;
    take   = offer && load_div != '0;
    // a pending divisor lands on a wrap, or immediately while the phase is frozen
    apply  = pend_q && (!en || last);
    cnt_d  = apply ? '0 : en ? cnt_n : cnt_q;
    div_d  = apply ? pdiv_q : div_q;
    wave_d = apply ? pdiv_q == WIDTH'(1) : en ? cnt_n >= (div_q >> 1) : wave_q;
    tick_d = en && last;
    pc_d   = pc_q + 16'(tick_d);
    pend_d = apply ? 1'b0 : take ? 1'b1 : pend_q;
    pdiv_d = take ? load_div : pdiv_q;
    err_d  = offer && load_div == '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= DEF;
      pdiv_q <= DEF;
      pc_q   <= '0;
      pend_q <= 1'b0;
      wave_q <= 1'b0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pdiv_q <= pdiv_d;
      pc_q   <= pc_d;
      pend_q <= pend_d;
      wave_q <= wave_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end
  assign load_ready   = !pend_q;
  assign load_err     = err_q;
  assign out_d        = wave_q;
  assign tick         = tick_q;
  assign div_active   = div_q;
  assign period_count = pc_q;
endmodule
